// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Also provides warm-up hazard suppression and saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          HAZRESET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        hazreset,
    output logic [15:0] stallcnt,
    output logic [15:0] flushcnt
);

    localparam logic [3:0] HAZ_INIT = 4'(HAZRESET_CYCLES);

    logic [31:0] pcplus4F;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic        jump_taken;
    logic        branch_taken;
    logic        flushD;
    logic [3:0]  hazcnt;

    assign pcplus4F     = pcF + 32'd4;
    assign jump_target  = {pcplus4D[31:28], instrD[25:0], 2'b00};
    // Decode-side redirects are only honoured once decode itself is free to advance.
    assign jump_taken   = jumpD  & ~stallD;
    assign branch_taken = pcsrcD & ~stallD;
    assign flushD       = jump_taken | branch_taken;
    assign hazreset     = (hazcnt != 4'd0);

    always_comb begin
        pc_next = pcplus4F;
        if (stallF)
            pc_next = pcF;
        else if (jump_taken)
            pc_next = jump_target;
        else if (branch_taken)
            pc_next = pcbranchD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF      <= RESET_PC;
            instrD   <= 32'd0;
            pcplus4D <= 32'd0;
            validD   <= 1'b0;
        end else begin
            pcF <= pc_next;
            if (!stallD) begin
                if (flushD) begin
                    instrD   <= 32'd0;
                    pcplus4D <= 32'd0;
                    validD   <= 1'b0;
                end else begin
                    instrD   <= instrF;
                    pcplus4D <= pcplus4F;
                    validD   <= 1'b1;
                end
            end
        end
    end

    // Warm-up counter: hazreset stays high until it has counted down to zero.
    always_ff @(posedge clk) begin
        if (reset)
            hazcnt <= HAZ_INIT;
        else if (hazcnt != 4'd0)
            hazcnt <= hazcnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallcnt <= 16'd0;
            flushcnt <= 16'd0;
        end else if (!hazreset) begin
            if (stallF && stallcnt != 16'hFFFF)
                stallcnt <= stallcnt + 16'd1;
            if (flushD && flushcnt != 16'hFFFF)
                flushcnt <= flushcnt + 16'd1;
        end
    end

endmodule
